// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB completer with a word register bank, programmed wait states and stall
//
// Ports:
//   PCLK, PRESETn                  clock (rising edge), asynchronous active-low reset
//   PSEL_slv_i, PENABLE_slv_i      APB select / access-phase flag
//   PWRITE_slv_i                   1 = write, 0 = read
//   PADDR_slv_i, PWDATA_slv_i      byte address and write data (sampled at the setup edge only)
//   STALL_slv_i                    freezes the wait counter and keeps PREADY low
//   PRDATA_slv_o                   read data, non-zero only while PREADY=1
//   PREADY_slv_o                   transfer completes this cycle
//   PSLVERR_slv_o                  error response for misaligned / out-of-range addresses

module apb_slave_regfile #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int REG_NUM     = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL_slv_i,
    input  logic                  PENABLE_slv_i,
    input  logic                  PWRITE_slv_i,
    input  logic [ADDR_WIDTH-1:0] PADDR_slv_i,
    input  logic [DATA_WIDTH-1:0] PWDATA_slv_i,
    input  logic                  STALL_slv_i,
    output logic [DATA_WIDTH-1:0] PRDATA_slv_o,
    output logic                  PREADY_slv_o,
    output logic                  PSLVERR_slv_o
);

    localparam int IDX_W = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam logic [7:0] WAIT_LD = 8'(WAIT_CYCLES);
    // One bit wider than the word index so REG_NUM == 2**(ADDR_WIDTH-2) does not wrap to 0.
    localparam logic [ADDR_WIDTH-2:0] REG_LIMIT = (ADDR_WIDTH-1)'(REG_NUM);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READY
    } state_t;

    state_t                state, state_nxt;
    logic [7:0]            cnt, cnt_nxt;

    logic [DATA_WIDTH-1:0] regs [REG_NUM];

    logic                  lat_write;
    logic                  lat_err;
    logic [IDX_W-1:0]      lat_idx;
    logic [DATA_WIDTH-1:0] lat_wdata;

    logic                  setup;
    logic                  in_err;
    logic [IDX_W-1:0]      in_idx;
    logic                  cur_write;
    logic                  cur_err;
    logic [IDX_W-1:0]      cur_idx;
    logic                  going_ready;
    logic                  commit_wr;

    assign setup  = PSEL_slv_i && !PENABLE_slv_i;
    assign in_err = (PADDR_slv_i[1:0] != 2'b00) ||
                    ({1'b0, PADDR_slv_i[ADDR_WIDTH-1:2]} >= REG_LIMIT);
    assign in_idx = PADDR_slv_i[2 +: IDX_W];

    // A zero-wait transfer enters READY straight from IDLE, before the latches
    // hold this transfer, so the output flops must look at the live bus then.
    assign cur_write = (state == ST_IDLE) ? PWRITE_slv_i : lat_write;
    assign cur_err   = (state == ST_IDLE) ? in_err       : lat_err;
    assign cur_idx   = (state == ST_IDLE) ? in_idx       : lat_idx;

    assign going_ready = (state_nxt == ST_READY);
    assign commit_wr   = (state == ST_READY) && PSEL_slv_i && PENABLE_slv_i &&
                         lat_write && !lat_err;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (setup) begin
                    cnt_nxt   = WAIT_LD;
                    state_nxt = (WAIT_LD == 8'd0 && !STALL_slv_i) ? ST_READY : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!PSEL_slv_i) begin
                    state_nxt = ST_IDLE;
                end else if (!STALL_slv_i) begin
                    if (cnt <= 8'd1) begin
                        state_nxt = ST_READY;
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
            end
            ST_READY: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= ST_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
        end else if (state == ST_IDLE && setup) begin
            lat_write <= PWRITE_slv_i;
            lat_err   <= in_err;
            lat_idx   <= in_idx;
            lat_wdata <= PWDATA_slv_i;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (commit_wr) begin
            regs[lat_idx] <= lat_wdata;
        end
    end

    // Response flops are loaded on the edge that enters READY, so they are
    // valid for exactly the READY cycle and cleared on the way out.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PREADY_slv_o  <= 1'b0;
            PSLVERR_slv_o <= 1'b0;
            PRDATA_slv_o  <= '0;
        end else begin
            PREADY_slv_o  <= going_ready;
            PSLVERR_slv_o <= going_ready && cur_err;
            PRDATA_slv_o  <= (going_ready && !cur_write && !cur_err) ? regs[cur_idx] : '0;
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - scoreboard bench for apb_slave_regfile (zero-wait and 3-wait instances)

module tb_apb_slave_regfile;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } exp_t;

    logic        pclk = 1'b0;
    logic        rstn;
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic        stall   [2];
    logic [15:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    logic [31:0] model [2][16];
    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 pclk = ~pclk;

    apb_slave_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .REG_NUM(16), .WAIT_CYCLES(0)) dut0 (
        .PCLK(pclk), .PRESETn(rstn),
        .PSEL_slv_i(psel[0]), .PENABLE_slv_i(penable[0]), .PWRITE_slv_i(pwrite[0]),
        .PADDR_slv_i(paddr[0]), .PWDATA_slv_i(pwdata[0]), .STALL_slv_i(stall[0]),
        .PRDATA_slv_o(prdata[0]), .PREADY_slv_o(pready[0]), .PSLVERR_slv_o(pslverr[0])
    );

    apb_slave_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .REG_NUM(16), .WAIT_CYCLES(3)) dut3 (
        .PCLK(pclk), .PRESETn(rstn),
        .PSEL_slv_i(psel[1]), .PENABLE_slv_i(penable[1]), .PWRITE_slv_i(pwrite[1]),
        .PADDR_slv_i(paddr[1]), .PWDATA_slv_i(pwdata[1]), .STALL_slv_i(stall[1]),
        .PRDATA_slv_o(prdata[1]), .PREADY_slv_o(pready[1]), .PSLVERR_slv_o(pslverr[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++)
                model[d][i] = 32'h0;
    endtask

    // One complete transfer on instance d; bus inputs are scrambled after the
    // setup edge, so any use of un-latched values shows up as a miscompare.
    task automatic xfer(input int d, input logic wr, input logic [15:0] addr, input logic [31:0] wdata);
        exp_t e;
        exp_t got;
        logic err;
        int   idx;
        int   waits;
        err     = (addr[1:0] != 2'b00) || (addr[15:2] >= 14'd16);
        idx     = int'(addr[5:2]);
        e.err   = err;
        e.rdata = (!wr && !err) ? model[d][idx] : 32'h0;
        e.waits = (d == 0) ? 0 : 3;
        sb.push_back(e);
        @(posedge pclk); #1;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wdata;
        @(posedge pclk); #1;
        penable[d] = 1'b1; pwrite[d] = ~wr; paddr[d] = addr ^ 16'h0004; pwdata[d] = ~wdata;
        waits = 0;
        while (!pready[d] && waits < 50) begin
            @(posedge pclk); #1;
            waits++;
        end
        got = sb.pop_front();
        if (!pready[d]) begin
            chk("pready_timeout", {31'h0, pready[d]}, 32'h1);
        end else begin
            chk("prdata", prdata[d], got.rdata);
            chk("pslverr", {31'h0, pslverr[d]}, {31'h0, got.err});
            chk("latency", 32'(waits), 32'(got.waits));
        end
        @(posedge pclk); #1;
        psel[d] = 1'b0; penable[d] = 1'b0;
        if (wr && !err) model[d][idx] = wdata;
    endtask

    initial begin
        int hi;
        logic [15:0] a;
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; stall[d] = 1'b0;
            paddr[d] = 16'h0; pwdata[d] = 32'h0;
        end
        clear_model();
        rstn = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_pready", {31'h0, pready[d]}, 32'h0);
            chk("rst_pslverr", {31'h0, pslverr[d]}, 32'h0);
            chk("rst_prdata", prdata[d], 32'h0);
        end
        rstn = 1'b1;

        // zero-wait write then read
        xfer(0, 1'b1, 16'h0004, 32'hDEADBEEF);
        xfer(0, 1'b0, 16'h0004, 32'h0);

        // three wait states, read of a cleared register
        xfer(1, 1'b0, 16'h0008, 32'h0);

        // out-of-range and misaligned writes are discarded
        xfer(0, 1'b1, 16'h0040, 32'h11111111);
        xfer(0, 1'b1, 16'h0006, 32'h22222222);
        xfer(0, 1'b0, 16'h0004, 32'h0);
        xfer(0, 1'b0, 16'h0040, 32'h0);

        // stall held through the access phase, then master abandons the transfer
        stall[0] = 1'b1;
        @(posedge pclk); #1;
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 16'h0010; pwdata[0] = 32'h12345678;
        @(posedge pclk); #1;
        penable[0] = 1'b1;
        hi = 0;
        repeat (20) begin
            if (pready[0]) hi++;
            @(posedge pclk); #1;
        end
        chk("stall_pready_cycles", 32'(hi), 32'h0);
        psel[0] = 1'b0; penable[0] = 1'b0; stall[0] = 1'b0;
        @(posedge pclk); #1;
        xfer(0, 1'b0, 16'h0010, 32'h0);

        // reset mid-transfer: dut3 in WAIT on a write, dut0 presenting read data
        @(posedge pclk); #1;
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 16'h000C; pwdata[1] = 32'hCAFEF00D;
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b0; paddr[0] = 16'h0004;
        @(posedge pclk); #1;
        penable[0] = 1'b1; penable[1] = 1'b1;
        chk("pre_rst_prdata0", prdata[0], 32'hDEADBEEF);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_prdata0", prdata[0], 32'h0);
        chk("mid_rst_pready0", {31'h0, pready[0]}, 32'h0);
        chk("mid_rst_pready3", {31'h0, pready[1]}, 32'h0);
        chk("mid_rst_pslverr3", {31'h0, pslverr[1]}, 32'h0);
        @(posedge pclk); #1;
        for (int d = 0; d < 2; d++) begin
            psel[d] = 1'b0; penable[d] = 1'b0;
        end
        rstn = 1'b1;
        clear_model();
        xfer(1, 1'b0, 16'h000C, 32'h0);
        xfer(0, 1'b0, 16'h0004, 32'h0);

        // random traffic on both instances against the reference model
        for (int i = 0; i < 100; i++) begin
            a = 16'($urandom_range(0, 17)) << 2;
            if ($urandom_range(0, 9) == 0) a = a | 16'h0002;
            xfer(i % 2, 1'($urandom_range(0, 1)), a, $urandom);
        end

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
